median_window_streamer: RTL and testbench

MEDIAN_WINDOW_STREAMER -- requirements
Module: median_window_streamer

---
 rtl/medwin_pkg.sv | 12 +
 rtl/median_window_streamer_if.sv | 46 ++++
 rtl/medwin_line_buffer.sv | 27 ++
 rtl/median_window_streamer.sv | 152 +++++++++++++++
 tb/tb_median_window_streamer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/medwin_pkg.sv
// Shared defaults and the 3x3 window type for the median window streamer.
package medwin_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned IMG_W_DEF = 400;
  localparam int unsigned IMG_H_DEF = 400;
  localparam int unsigned WIN_N     = 9;

  // Index 0..2 = row r-2, 3..5 = row r-1, 6..8 = row r; left to right within a row.
  typedef logic [WIN_N-1:0][PIX_W_DEF-1:0] win_t;

endpackage

// File: rtl/median_window_streamer_if.sv
// Pixel-in / window-out handshake bundle. in_sof exists only when MEDWIN_SOF_EN is defined.
interface median_window_streamer_if
  import medwin_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) ();

  logic             in_valid;
  logic [PIX_W-1:0] in_pixel;
  logic             in_ready;
`ifdef MEDWIN_SOF_EN
  logic             in_sof;
`endif
  logic             win_valid;
  logic             win_ready;
  logic [PIX_W-1:0] win_p0;
  logic [PIX_W-1:0] win_p1;
  logic [PIX_W-1:0] win_p2;
  logic [PIX_W-1:0] win_p3;
  logic [PIX_W-1:0] win_p4;
  logic [PIX_W-1:0] win_p5;
  logic [PIX_W-1:0] win_p6;
  logic [PIX_W-1:0] win_p7;
  logic [PIX_W-1:0] win_p8;
  logic             win_last;
  logic             frame_done;

  modport slave (
`ifdef MEDWIN_SOF_EN
    input  in_sof,
`endif
    input  in_valid, in_pixel, win_ready,
    output in_ready, win_valid, win_p0, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6,
           win_p7, win_p8, win_last, frame_done
  );

  modport master (
`ifdef MEDWIN_SOF_EN
    output in_sof,
`endif
    output in_valid, in_pixel, win_ready,
    input  in_ready, win_valid, win_p0, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6,
           win_p7, win_p8, win_last, frame_done
  );

endinterface

// File: rtl/medwin_line_buffer.sv
// One image row of storage: single write port, asynchronous read; a read and write
// at the same address in one cycle returns the old contents.
module medwin_line_buffer
  import medwin_pkg::*;
#(
  parameter int unsigned Depth = IMG_W_DEF,
  parameter int unsigned Width = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  input  logic [Width-1:0]         i_wdata,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  assign o_rdata = r_mem[i_raddr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/median_window_streamer.sv
// Raster pixel stream to 3x3 window stream (interior windows only).
// Optional MEDWIN_SOF_EN adds in_sof, forcing the accepted pixel to position (0,0).
module median_window_streamer
  import medwin_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input logic                     clk,
  input logic                     rst_n,
  median_window_streamer_if.slave bus
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColFirst = CW'(2);
  localparam logic [RW-1:0] RowFirst = RW'(2);

  logic [CW-1:0] r_col_cnt, w_col_nxt, w_pos_col;
  logic [RW-1:0] r_row_cnt, w_row_nxt, w_pos_row;
  logic          w_sof;
  logic          w_in_ready;
  logic          w_acc;
  logic          w_qual;
  logic          w_is_last;

  logic [PIX_W-1:0]      w_r1_pix;
  logic [PIX_W-1:0]      w_r2_pix;
  logic [2:0][PIX_W-1:0] w_new_col;
  logic [2:0][PIX_W-1:0] r_sh1;
  logic [2:0][PIX_W-1:0] r_sh2;
  logic [8:0][PIX_W-1:0] w_win;
  logic [8:0][PIX_W-1:0] r_win;
  logic                  r_win_valid;
  logic                  r_win_last;
  logic                  r_frame_done;

`ifdef MEDWIN_SOF_EN
  assign w_sof = bus.in_sof;
`else
  assign w_sof = 1'b0;
`endif

  // Position of the pixel currently offered; start-of-frame overrides the counters.
  assign w_pos_col = w_sof ? '0 : r_col_cnt;
  assign w_pos_row = w_sof ? '0 : r_row_cnt;

  assign w_in_ready = !r_win_valid || bus.win_ready;
  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_qual     = (w_pos_col >= ColFirst) && (w_pos_row >= RowFirst);
  assign w_is_last  = (w_pos_col == ColLast) && (w_pos_row == RowLast);

  always_comb begin
    w_col_nxt = r_col_cnt;
    w_row_nxt = r_row_cnt;
    if (w_acc) begin
      if (w_pos_col == ColLast) begin
        w_col_nxt = '0;
        w_row_nxt = (w_pos_row == RowLast) ? '0 : w_pos_row + RW'(1);
      end else begin
        w_col_nxt = w_pos_col + CW'(1);
        w_row_nxt = w_pos_row;
      end
    end
  end

  // Row r-1 buffer feeds the row r-2 buffer, both indexed by the current column.
  medwin_line_buffer #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_lb_r1 (
    .clk     (clk),
    .i_we    (w_acc),
    .i_waddr (w_pos_col),
    .i_raddr (w_pos_col),
    .i_wdata (bus.in_pixel),
    .o_rdata (w_r1_pix)
  );

  medwin_line_buffer #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_lb_r2 (
    .clk     (clk),
    .i_we    (w_acc),
    .i_waddr (w_pos_col),
    .i_raddr (w_pos_col),
    .i_wdata (w_r1_pix),
    .o_rdata (w_r2_pix)
  );

  assign w_new_col[0] = w_r2_pix;
  assign w_new_col[1] = w_r1_pix;
  assign w_new_col[2] = bus.in_pixel;

  // Columns c-2 and c-1 come from the shift register, column c straight from the inputs.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < 3; i++) begin
      w_win[3*i]   = r_sh2[i];
      w_win[3*i+1] = r_sh1[i];
      w_win[3*i+2] = w_new_col[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_sh1        <= '0;
      r_sh2        <= '0;
      r_win        <= '0;
      r_win_valid  <= 1'b0;
      r_win_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_col_cnt    <= w_col_nxt;
      r_row_cnt    <= w_row_nxt;
      r_frame_done <= r_win_valid && bus.win_ready && r_win_last;
      if (w_acc) begin
        r_sh2       <= r_sh1;
        r_sh1       <= w_new_col;
        r_win_valid <= w_qual;
        r_win_last  <= w_qual && w_is_last;
        if (w_qual) begin
          r_win <= w_win;
        end
      end else if (bus.win_ready) begin
        r_win_valid <= 1'b0;
        r_win_last  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_last   = r_win_last;
  assign bus.frame_done = r_frame_done;
  assign bus.win_p0     = r_win[0];
  assign bus.win_p1     = r_win[1];
  assign bus.win_p2     = r_win[2];
  assign bus.win_p3     = r_win[3];
  assign bus.win_p4     = r_win[4];
  assign bus.win_p5     = r_win[5];
  assign bus.win_p6     = r_win[6];
  assign bus.win_p7     = r_win[7];
  assign bus.win_p8     = r_win[8];

endmodule

// File: tb/tb_median_window_streamer.sv
// Directed bench for median_window_streamer on a 4x4 image with a window scoreboard.
module tb_median_window_streamer;
  import medwin_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  typedef struct {
    win_t win;
    logic last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  median_window_streamer_if #(.PIX_W(8)) bus ();

  median_window_streamer #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       sb [$];
  exp_t       e_pop;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         n_win    = 0;
  logic       exp_fd   = 1'b0;
  logic [7:0] img [H][W];
  int         m_row    = 0;
  int         m_col    = 0;
  win_t       cw;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic win_t obs_win();
    win_t w;
    w[0] = bus.win_p0; w[1] = bus.win_p1; w[2] = bus.win_p2;
    w[3] = bus.win_p3; w[4] = bus.win_p4; w[5] = bus.win_p5;
    w[6] = bus.win_p6; w[7] = bus.win_p7; w[8] = bus.win_p8;
    return w;
  endfunction

  // Offer one pixel, wait for acceptance, then record it in the image model.
  task automatic send(input logic [7:0] pix, input logic sof);
    logic acc;
    int   guard;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_pixel = pix;
`ifdef MEDWIN_SOF_EN
    bus.in_sof = sof;
`endif
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("accept_timeout", bus.in_ready, 1);
`ifdef MEDWIN_SOF_EN
    bus.in_sof = 1'b0;
`endif
    if (sof) begin
      m_row = 0;
      m_col = 0;
    end
    img[m_row][m_col] = pix;
    if (m_row >= 2 && m_col >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win[3*i+j] = img[m_row-2+i][m_col-2+j];
      e.last = (m_row == H - 1) && (m_col == W - 1);
      sb.push_back(e);
    end
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_win_valid"}, bus.win_valid, 0);
    check({tag, "_win_last"}, bus.win_last, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_window"}, obs_win(), 0);
  endtask

  // Consumer-side scoreboard: compare every handshaken window and the following frame_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_fd = 1'b0;
    end else begin
      check("frame_done", bus.frame_done, exp_fd);
      exp_fd = 1'b0;
      if (bus.win_valid && bus.win_ready) begin
        if (sb.size() == 0) begin
          check("spurious_window", bus.win_valid, 0);
        end else begin
          e_pop = sb.pop_front();
          check("window", obs_win(), e_pop.win);
          check("win_last", bus.win_last, e_pop.last);
          exp_fd = e_pop.last;
          n_win++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.win_ready = 1'b1;
`ifdef MEDWIN_SOF_EN
    bus.in_sof = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    check("reset_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two frames back to back, second frame offset by 100.
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    for (int i = 0; i < 16; i++) send(8'(100 + i), 1'b0);
    idle(4);
    check("windows_two_frames", n_win, 8);

    // Downstream stall on the first window of a frame.
    n_win = 0;
    bus.win_ready = 1'b0;
    for (int i = 0; i <= 10; i++) send(8'(i), 1'b0);
    bus.in_valid = 1'b0;
    cw = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_win_valid", bus.win_valid, 1);
      check("stall_window", obs_win(), cw);
    end
    @(posedge clk);
    #1;
    bus.win_ready = 1'b1;
    for (int i = 11; i < 16; i++) send(8'(i), 1'b0);
    idle(4);
    check("windows_stall", n_win, 4);

    // Reset in the middle of a frame, then a clean frame.
    n_win = 0;
    for (int i = 0; i < 9; i++) send(8'(i), 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    sb.delete();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    idle(4);
    check("windows_after_reset", n_win, 4);

`ifdef MEDWIN_SOF_EN
    n_win = 0;
    for (int i = 0; i < 7; i++) send(8'(50 + i), 1'b0);
    send(8'd60, 1'b1);
    for (int i = 0; i < 15; i++) send(8'(61 + i), 1'b0);
    idle(4);
    check("windows_sof", n_win, 4);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
